// File: rtl/matrix2ram.sv
`default_nettype none
// ============================================================================
// matrix2ram - snapshots a matrix, writes it to a single-port RAM, reads it
//              back and reports done / error / mismatch count.
// Revision   : 1.0
// ============================================================================
module matrix2ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 16,
  parameter int DATA_AMOUNT = 16,
  parameter int BASE_ADDR   = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [$clog2(DATA_AMOUNT):0]           data_amt,
  input  logic [DATA_AMOUNT-1:0][DATA_WIDTH-1:0] matrix_data,
  output logic                                   ram_we,
  output logic                                   ram_re,
  output logic [$clog2(DEPTH)-1:0]               ram_addr,
  output logic [DATA_WIDTH-1:0]                  ram_wdata,
  input  logic [DATA_WIDTH-1:0]                  ram_rdata,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [$clog2(DATA_AMOUNT):0]           err_count
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(DATA_AMOUNT) + 1;
  localparam int IDX_WIDTH  = (DATA_AMOUNT > 1) ? $clog2(DATA_AMOUNT) : 1;
  localparam int ROOM       = DEPTH - BASE_ADDR;
  localparam int MAX_N_INT  = (DATA_AMOUNT < ROOM) ? DATA_AMOUNT : ROOM;
  localparam logic [CNT_WIDTH-1:0]  MAX_N   = CNT_WIDTH'(MAX_N_INT);
  localparam logic [CNT_WIDTH-1:0]  ERR_SAT = CNT_WIDTH'(DATA_AMOUNT);
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                                 state_q, state_d;
  logic [DATA_AMOUNT-1:0][DATA_WIDTH-1:0] snap_q, snap_d;
  logic [CNT_WIDTH-1:0]                   n_q, n_d;
  logic [IDX_WIDTH-1:0]                   idx_q, idx_d;
  logic                                   pend_q, pend_d;
  logic [IDX_WIDTH-1:0]                   pend_idx_q, pend_idx_d;
  logic                                   ram_we_q, ram_we_d;
  logic                                   ram_re_q, ram_re_d;
  logic [ADDR_WIDTH-1:0]                  ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]                  ram_wdata_q, ram_wdata_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic                                   error_q, error_d;
  logic [CNT_WIDTH-1:0]                   err_count_q, err_count_d;

  logic [CNT_WIDTH-1:0] n_clamped;
  logic [IDX_WIDTH-1:0] idx_next;
  logic                 is_last;
  logic                 mismatch;

  assign n_clamped = (data_amt > MAX_N) ? MAX_N : data_amt;
  assign idx_next  = idx_q + IDX_WIDTH'(1);
  assign is_last   = (CNT_WIDTH'(idx_q) == (n_q - CNT_WIDTH'(1)));
  // pend_q marks that read data for element pend_idx_q arrives this cycle
  assign mismatch  = pend_q && (ram_rdata != snap_q[pend_idx_q]);

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    n_d         = n_q;
    idx_d       = idx_q;
    pend_d      = ram_re_q;
    pend_idx_d  = idx_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_count_d = err_count_q;

    if (mismatch) begin
      error_d = 1'b1;
      if (err_count_q != ERR_SAT) begin
        err_count_d = err_count_q + CNT_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d      = matrix_data;
          n_d         = n_clamped;
          idx_d       = '0;
          error_d     = 1'b0;
          err_count_d = '0;
          if (n_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = WRITE;
            busy_d      = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = BASE;
            ram_wdata_d = matrix_data[0];
          end
        end
      end
      WRITE: begin
        if (is_last) begin
          state_d    = READ;
          ram_re_d   = 1'b1;
          ram_addr_d = BASE;
          idx_d      = '0;
        end else begin
          ram_we_d    = 1'b1;
          idx_d       = idx_next;
          ram_addr_d  = ram_addr_q + ADDR_WIDTH'(1);
          ram_wdata_d = snap_q[idx_next];
        end
      end
      READ: begin
        if (is_last) begin
          state_d = DRAIN;
        end else begin
          ram_re_d   = 1'b1;
          idx_d      = idx_next;
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      n_q         <= '0;
      idx_q       <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      n_q         <= n_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_re    = ram_re_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix2ram.sv
`default_nettype none
// ============================================================================
// tb_matrix2ram - directed + randomized bench; instance A at base 0 with a
//                 fault-injecting RAM, instance B at base 12 with an ideal RAM.
// Revision      : 1.0
// ============================================================================
module tb_matrix2ram;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             start_a, start_b;
  logic [4:0]       amt_a, amt_b;
  logic [15:0][7:0] md_a, md_b;
  logic             we_a, re_a, busy_a, done_a, error_a;
  logic             we_b, re_b, busy_b, done_b, error_b;
  logic [3:0]       addr_a, addr_b;
  logic [7:0]       wdata_a, wdata_b, rdata_a, rdata_b;
  logic [4:0]       errc_a, errc_b;
  logic [7:0]       mem_a [16];
  logic [7:0]       mem_b [16];
  logic [7:0]       flt_a [16];
  int               checks = 0;
  int               errors = 0;

  matrix2ram #(.DATA_WIDTH(8), .DEPTH(16), .DATA_AMOUNT(16), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .data_amt(amt_a), .matrix_data(md_a),
    .ram_we(we_a), .ram_re(re_a), .ram_addr(addr_a), .ram_wdata(wdata_a),
    .ram_rdata(rdata_a), .busy(busy_a), .done(done_a), .error(error_a),
    .err_count(errc_a)
  );

  matrix2ram #(.DATA_WIDTH(8), .DEPTH(16), .DATA_AMOUNT(16), .BASE_ADDR(12)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .data_amt(amt_b), .matrix_data(md_b),
    .ram_we(we_b), .ram_re(re_b), .ram_addr(addr_b), .ram_wdata(wdata_b),
    .ram_rdata(rdata_b), .busy(busy_b), .done(done_b), .error(error_b),
    .err_count(errc_b)
  );

  // RAM models: registered read, A corrupts readback by XOR with flt_a
  always @(posedge clk) begin
    if (we_a) mem_a[addr_a] <= wdata_a;
    if (re_a) rdata_a <= mem_a[addr_a] ^ flt_a[addr_a];
    if (we_b) mem_b[addr_b] <= wdata_b;
    if (re_b) rdata_b <= mem_b[addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer from accept to done, checked against a min()/count model.
  task automatic transfer(input bit sel, input int amt, input bit scramble, input string tag);
    int base, n, cyc, nwe, nre, both, bad_addr, bad_data, bad_mem, exp_err, widx, ridx;
    logic [15:0][7:0] snap;
    logic w, r, d;
    logic [3:0] ad;
    logic [7:0] wd, mv;
    base = sel ? 12 : 0;
    n = amt;
    if (n > 16) n = 16;
    if (n > 16 - base) n = 16 - base;
    snap = sel ? md_b : md_a;
    exp_err = 0;
    for (int j = 0; j < n; j++) if (!sel && flt_a[base + j] != 8'd0) exp_err++;
    if (sel) begin start_b = 1'b1; amt_b = 5'(amt); end
    else begin start_a = 1'b1; amt_a = 5'(amt); end
    nwe = 0; nre = 0; both = 0; bad_addr = 0; bad_data = 0; bad_mem = 0; widx = 0; ridx = 0;
    @(posedge clk);
    cyc = 0;
    while (cyc < 100) begin
      #1;
      cyc++;
      w  = sel ? we_b : we_a;
      r  = sel ? re_b : re_a;
      d  = sel ? done_b : done_a;
      ad = sel ? addr_b : addr_a;
      wd = sel ? wdata_b : wdata_a;
      if (w && r) both++;
      if (w) begin
        if (ad != 4'(base + widx)) bad_addr++;
        if (widx >= 16 || wd !== snap[widx]) bad_data++;
        widx++;
        nwe++;
      end
      if (r) begin
        if (ad != 4'(base + ridx)) bad_addr++;
        ridx++;
        nre++;
      end
      if (scramble && cyc == 3) begin
        if (sel) begin md_b = {$urandom, $urandom, $urandom, $urandom}; amt_b = 5'($urandom); end
        else begin md_a = {$urandom, $urandom, $urandom, $urandom}; amt_a = 5'($urandom); end
      end
      if (d) break;
      @(posedge clk);
    end
    for (int j = 0; j < n; j++) begin
      mv = sel ? mem_b[base + j] : mem_a[base + j];
      if (mv !== snap[j]) bad_mem++;
    end
    chk({tag, ".done_cycle"}, cyc, (n == 0) ? 1 : 2 * n + 2);
    chk({tag, ".writes"}, nwe, n);
    chk({tag, ".reads"}, nre, n);
    chk({tag, ".we_re_overlap"}, both, 0);
    chk({tag, ".addr"}, bad_addr, 0);
    chk({tag, ".wdata"}, bad_data, 0);
    chk({tag, ".ram_contents"}, bad_mem, 0);
    chk({tag, ".busy"}, sel ? busy_b : busy_a, 0);
    chk({tag, ".error"}, sel ? error_b : error_a, (exp_err != 0) ? 1 : 0);
    chk({tag, ".err_count"}, sel ? errc_b : errc_a, exp_err);
    @(negedge clk);
  endtask

  task automatic release_start(input bit sel, input string tag);
    if (sel) start_b = 1'b0; else start_a = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".done_drop"}, sel ? done_b : done_a, 0);
    @(negedge clk);
  endtask

  initial begin
    int hold_bad;
    reset = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    amt_a = '0; amt_b = '0;
    md_a = '0; md_b = '0;
    for (int i = 0; i < 16; i++) flt_a[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ctrl", {we_a, re_a, busy_a, done_a, error_a}, 0);
    chk("reset.err_count", errc_a, 0);
    chk("reset.addr", addr_a, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) md_a[i] = 8'(i * 3 + 1);
    transfer(1'b0, 16, 1'b0, "full");
    release_start(1'b0, "full");

    flt_a[5] = 8'h01;
    flt_a[9] = 8'h01;
    md_a = {$urandom, $urandom, $urandom, $urandom};
    transfer(1'b0, 16, 1'b0, "fault");
    release_start(1'b0, "fault");
    for (int i = 0; i < 16; i++) flt_a[i] = 8'd0;

    md_b = {$urandom, $urandom, $urandom, $urandom};
    transfer(1'b1, 16, 1'b0, "clamp");
    release_start(1'b1, "clamp");

    transfer(1'b0, 0, 1'b0, "zero");
    release_start(1'b0, "zero");

    md_a = {$urandom, $urandom, $urandom, $urandom};
    start_a = 1'b1;
    amt_a = 5'd16;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst.mid_write", we_a, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.outputs", {we_a, re_a, busy_a, done_a, error_a, errc_a, addr_a, wdata_a}, 0);
    @(negedge clk);
    reset = 1'b0;
    md_a = {$urandom, $urandom, $urandom, $urandom};
    transfer(1'b0, 16, 1'b0, "rst_restart");
    release_start(1'b0, "rst_restart");

    md_a = {$urandom, $urandom, $urandom, $urandom};
    transfer(1'b0, 16, 1'b1, "hs");
    hold_bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (we_a || re_a || !done_a) hold_bad++;
    end
    chk("hs.no_retrigger", hold_bad, 0);
    @(negedge clk);
    release_start(1'b0, "hs");
    md_a = {$urandom, $urandom, $urandom, $urandom};
    transfer(1'b0, 16, 1'b0, "hs_again");
    release_start(1'b0, "hs_again");

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++)
        flt_a[i] = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      md_a = {$urandom, $urandom, $urandom, $urandom};
      md_b = {$urandom, $urandom, $urandom, $urandom};
      transfer(k[0], int'($urandom_range(0, 20)), 1'b1, "rand");
      release_start(k[0], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matrix2ram.md
Name: matrix2ram

Overview:
- Write-direction companion to the ROM-to-RAM loader.
- Takes a matrix array (e.g. compute results) and snapshots it on start.
- Writes the elements, one per cycle, into an external single-port RAM at consecutive addresses.
- Reads every written word back, compares it against the snapshot, then reports done, error and a mismatch count.

Parameters:
- DATA_WIDTH, 8, width of one matrix element / RAM word.
- DEPTH, 16, RAM depth in words; ADDR_WIDTH = $clog2(DEPTH) (localparam).
- DATA_AMOUNT, 16, number of elements in matrix_data.
- BASE_ADDR, 0, first RAM address written.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; accepted only in IDLE.
- data_amt  in  $clog2(DATA_AMOUNT)+1  element count, sampled on accept.
- matrix_data  in  DATA_WIDTH x [DATA_AMOUNT-1:0]  source elements, sampled on accept.
- ram_we  out  1  RAM write enable.
- ram_re  out  1  RAM read enable.
- ram_addr  out  ADDR_WIDTH  RAM address, shared by read and write.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_re.
- busy  out  1  high from the cycle after accept until done rises.
- done  out  1  transfer and check complete.
- error  out  1  at least one readback mismatch.
- err_count  out  $clog2(DATA_AMOUNT)+1  number of mismatches.

Behaviour:
- Reset (sync, active-high): state IDLE; all outputs 0; snapshot, counters and err_count cleared.
  - Reset mid-transfer abandons the transfer immediately; the next cycle issues no further we/re.
- Count N = min(data_amt, DATA_AMOUNT, DEPTH-BASE_ADDR), computed at accept.
- IDLE:
  - On start=1 at cycle 0: latch all matrix_data into the snapshot, latch N, clear error and err_count.
  - Go to WRITE, or to DONE when N=0.
- WRITE, cycles 1..N: ram_we=1, ram_addr=BASE_ADDR+i, ram_wdata=snapshot[i], i=0..N-1. After the last write go to READ.
- READ, cycles N+1..2N: ram_re=1, ram_addr=BASE_ADDR+j.
  - The compare for element j happens in cycle N+2+j against snapshot[j].
  - On mismatch: err_count+1 and error=1.
- DRAIN, cycle 2N+1: final compare only, no we/re. Then go to DONE.
- DONE, from cycle 2N+2:
  - done=1, busy=0; error and err_count hold.
  - Stay in DONE while start=1; go to IDLE on the first cycle start=0, with done dropping that cycle.
  - A new start is accepted only in IDLE, so holding start high gives exactly one transfer.
- N=0: cycle 0 accept, then done=1 at cycle 1; no RAM access; error=0.
- start in WRITE/READ/DRAIN is ignored.
- Changes to matrix_data or data_amt after accept have no effect.
- ram_we and ram_re are never high in the same cycle.
- ram_addr stays at the last value when idle; its value is don't-care when we=re=0.
- Address arithmetic is ADDR_WIDTH wide and never wraps, because N is clamped.
- err_count saturates at DATA_AMOUNT.

Test Plan:
- Full transfer with an ideal RAM model:
  - Stimulus: data_amt=16, matrix_data[i]=i*3+1, start held high.
  - Response: 16 writes at addresses 0..15, then 16 reads; done=1 at cycle 34, error=0, err_count=0; RAM holds 1,4,...,46.
- Readback fault:
  - Stimulus: data_amt=16; the RAM model flips bit 0 at addresses 5 and 9.
  - Response: done at cycle 34, error=1, err_count=2.
- Clamp with offset:
  - Stimulus: BASE_ADDR=12, DEPTH=16, data_amt=16.
  - Response: N=4, writes to 12..15 only, done at cycle 10, no address wrap.
- Zero count:
  - Stimulus: data_amt=0, start=1.
  - Response: done=1 at cycle 1; ram_we and ram_re stay 0 throughout.
- Reset mid-write:
  - Stimulus: reset=1 at cycle 6 of a 16-word transfer.
  - Response: the next cycle has all outputs 0 and state IDLE. After reset drops, with start still high, a fresh transfer starts from address BASE_ADDR.
- Start handshake:
  - Stimulus: hold start high after done, toggle matrix_data during WRITE, then drop start.
  - Response: written data equals the snapshot taken at accept; no second transfer while start stays high; done falls the cycle start=0 is seen; a re-assert starts a new transfer.
